// File: rtl/csa3_pipe_acc.sv
// ============================================================================
// csa3_pipe_acc : two-stage 3:2 carry-save adder with running accumulator
// Revision 1.0
// ============================================================================
`default_nettype none

module csa3_pipe_acc #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH+1:0]     z,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_ovf
);

  if (WIDTH < 2) begin : g_width_check
    $error("csa3_pipe_acc: WIDTH must be >= 2");
  end
  if (ACC_WIDTH < WIDTH + 2) begin : g_acc_width_check
    $error("csa3_pipe_acc: ACC_WIDTH must be >= WIDTH+2");
  end

  logic                 live_q;
  logic                 s1_valid_q;
  logic [WIDTH-1:0]     s1_s_q;
  logic [WIDTH:0]       s1_k_q;
  logic                 s1_upd_q;
  logic                 s1_clr_q;
  logic                 s2_valid_q;
  logic [WIDTH+1:0]     z_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;

  logic                 s2_adv;
  logic                 s1_adv;
  logic                 in_fire;
  logic [WIDTH-1:0]     s_d;
  logic [WIDTH:0]       k_d;
  logic [WIDTH+1:0]     z_d;
  logic [ACC_WIDTH:0]   z_ext;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 ovf_d;

  // A slot may load when it is empty or its occupant leaves in the same cycle.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = live_q && s1_adv;
  assign in_fire  = in_valid && in_ready;

  assign s_d = a ^ b ^ c;
  assign k_d = {(a & b) | (a & c) | (b & c), 1'b0};

  assign z_d     = {2'b00, s1_s_q} + {1'b0, s1_k_q};
  assign z_ext   = {{(ACC_WIDTH - WIDTH - 1){1'b0}}, z_d};
  assign acc_sum = {1'b0, acc_q} + z_ext;

  // Clear has priority over enable; the carry out of the add marks a wrap.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (s1_clr_q) begin
      acc_d = z_ext[ACC_WIDTH-1:0];
      ovf_d = 1'b0;
    end else if (s1_upd_q) begin
      acc_d = acc_sum[ACC_WIDTH-1:0];
      ovf_d = ovf_q | acc_sum[ACC_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_s_q     <= '0;
      s1_k_q     <= '0;
      s1_upd_q   <= 1'b0;
      s1_clr_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (s1_adv) begin
        s1_valid_q <= in_fire;
        if (in_fire) begin
          s1_s_q   <= s_d;
          s1_k_q   <= k_d;
          s1_upd_q <= acc_en | acc_clr;
          s1_clr_q <= acc_clr;
        end
      end
      // Accumulator moves only when a beat enters stage 2, so stalls never recount.
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          z_q   <= z_d;
          acc_q <= acc_d;
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign z         = z_q;
  assign acc       = acc_q;
  assign acc_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_csa3_pipe_acc.sv
// ============================================================================
// tb_csa3_pipe_acc : scoreboard bench, runs 16-bit and 10-bit accumulators in lockstep
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_csa3_pipe_acc;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0;
  logic       acc_en = 1'b0, acc_clr = 1'b0;
  logic       out_ready = 1'b1;

  logic        in_ready, ir10;
  logic        out_valid, ov10;
  logic [9:0]  z16, z10;
  logic [15:0] acc16;
  logic [9:0]  acc10;
  logic        ovf16, ovf10;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0]  z;
    logic [15:0] acc16;
    logic        ovf16;
    logic [9:0]  acc10;
    logic        ovf10;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_sb;
  int   m16 = 0, m10 = 0;
  logic o16 = 1'b0, o10 = 1'b0;

  always #5 clk = ~clk;

  csa3_pipe_acc #(.WIDTH(8), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z16), .acc(acc16), .acc_ovf(ovf16)
  );

  csa3_pipe_acc #(.WIDTH(8), .ACC_WIDTH(10)) dut10 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir10),
    .a(a), .b(b), .c(c), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(ov10), .out_ready(out_ready),
    .z(z10), .acc(acc10), .acc_ovf(ovf10)
  );

  // Reset discards in-flight beats and restarts both reference accumulators.
  always @(negedge reset) begin
    exp_q.delete();
    m16 = 0; m10 = 0; o16 = 1'b0; o10 = 1'b0;
  end

  // Handshakes are sampled mid-cycle; the next rising edge completes them.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got beat z=%0d acc=%0d, required no pending beat", z16, acc16);
        end else begin
          e_sb = exp_q.pop_front();
          if (z16 !== e_sb.z || z10 !== e_sb.z || acc16 !== e_sb.acc16 || ovf16 !== e_sb.ovf16 ||
              acc10 !== e_sb.acc10 || ovf10 !== e_sb.ovf10 || ov10 !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_beat: got z=%0d acc=%0d ovf=%0d acc10=%0d ovf10=%0d, required z=%0d acc=%0d ovf=%0d acc10=%0d ovf10=%0d",
                     z16, acc16, ovf16, acc10, ovf10, e_sb.z, e_sb.acc16, e_sb.ovf16, e_sb.acc10, e_sb.ovf10);
          end
        end
      end
      if (in_valid && in_ready) begin
        int zv, s;
        zv = int'(a) + int'(b) + int'(c);
        if (acc_clr) begin
          m16 = zv; o16 = 1'b0; m10 = zv; o10 = 1'b0;
        end else if (acc_en) begin
          s = m16 + zv; if (s >= 65536) o16 = 1'b1; m16 = s % 65536;
          s = m10 + zv; if (s >= 1024)  o10 = 1'b1; m10 = s % 1024;
        end
        exp_q.push_back('{z: 10'(zv), acc16: 16'(m16), ovf16: o16, acc10: 10'(m10), ovf10: o10});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive a beat just after an edge and hold it until the bench sees it accepted.
  task automatic send(input logic [7:0] xa, xb, xc, input logic en, clr, output int waited);
    logic ok;
    a = xa; b = xb; c = xc; acc_en = en; acc_clr = clr; in_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk); ok = in_ready;
      tick();
      waited++;
    end while (!ok && waited < 50);
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got no accept in %0d cycles, required accept", waited);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || z16 !== 10'd0 || acc16 !== 16'd0 || ovf16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got in_ready=%0b out_valid=%0b z=%0d acc=%0d ovf=%0b, required 0 0 0 0 0",
               in_ready, out_valid, z16, acc16, ovf16);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got in_ready=%0b, required 1", in_ready);
    end
  endtask

  task automatic test_single();
    int w;
    out_ready = 1'b1;
    send(8'd45, 8'd72, 8'd56, 1'b0, 1'b0, w);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: got out_valid=%0b one edge after drive, required 0", out_valid);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || z16 !== 10'd173 || acc16 !== 16'd0) begin
      n_fail++;
      $display("FAIL single_out: got valid=%0b z=%0d acc=%0d, required 1 173 0", out_valid, z16, acc16);
    end
  endtask

  task automatic test_corner();
    int w;
    send(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, w);
    send(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, w);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || z16 !== 10'h2FD) begin
      n_fail++;
      $display("FAIL corner_max: got valid=%0b z=%0d, required 1 765", out_valid, z16);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || z16 !== 10'd0) begin
      n_fail++;
      $display("FAIL corner_zero: got valid=%0b z=%0d, required 1 0", out_valid, z16);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int w, total;
    total = 0;
    send(8'd45, 8'd72, 8'd56, 1'b1, 1'b1, w);  total += w;
    send(8'd66, 8'd62, 8'd48, 1'b1, 1'b0, w);  total += w;
    send(8'd92, 8'd85, 8'd74, 1'b1, 1'b0, w);  total += w;
    send(8'd12, 8'd27, 8'd143, 1'b1, 1'b0, w); total += w;
    in_valid = 1'b0;
    n_tests++;
    if (total !== 4) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d cycles for 4 beats, required 4", total);
    end
    n_tests++;
    if (z16 !== 10'd251 || acc16 !== 16'd600) begin
      n_fail++;
      $display("FAIL b2b_third: got z=%0d acc=%0d, required 251 600", z16, acc16);
    end
    tick();
    n_tests++;
    if (z16 !== 10'd182 || acc16 !== 16'd782) begin
      n_fail++;
      $display("FAIL b2b_last: got z=%0d acc=%0d, required 182 782", z16, acc16);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] ba[6] = '{8'd1, 8'd20, 8'd33, 8'd200, 8'd7, 8'd99};
    logic [7:0] bb[6] = '{8'd2, 8'd21, 8'd44, 8'd201, 8'd8, 8'd98};
    logic [7:0] bc[6] = '{8'd3, 8'd22, 8'd55, 8'd202, 8'd9, 8'd97};
    int idx, outs, cyc;
    logic stalled, seen_block;
    logic [9:0]  pz;
    logic [15:0] pacc;
    logic        povf;
    idx = 0; outs = 0; cyc = 0; stalled = 1'b0; seen_block = 1'b0;
    pz = '0; pacc = '0; povf = 1'b0;
    while (outs < 6 && cyc < 60) begin
      in_valid  = (idx < 6);
      a = ba[idx % 6]; b = bb[idx % 6]; c = bc[idx % 6];
      acc_clr = (idx == 0); acc_en = 1'b1;
      out_ready = !(cyc >= 2 && cyc <= 4);
      @(negedge clk);
      if (stalled) begin
        n_tests++;
        if (out_valid !== 1'b1 || z16 !== pz || acc16 !== pacc || ovf16 !== povf) begin
          n_fail++;
          $display("FAIL bp_hold: got valid=%0b z=%0d acc=%0d, required 1 %0d %0d", out_valid, z16, acc16, pz, pacc);
        end
      end
      if (!in_ready && in_valid) seen_block = 1'b1;
      stalled = out_valid && !out_ready;
      pz = z16; pacc = acc16; povf = ovf16;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) outs++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++;
    if (outs !== 6 || idx !== 6) begin
      n_fail++;
      $display("FAIL bp_count: got %0d in %0d out, required 6 6", idx, outs);
    end
    n_tests++;
    if (seen_block !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_drop: got in_ready never low with 2 held, required a drop");
    end
  endtask

  task automatic test_overflow();
    int w;
    out_ready = 1'b1;
    send(8'd255, 8'd255, 8'd255, 1'b0, 1'b1, w);
    send(8'd255, 8'd255, 8'd255, 1'b1, 1'b0, w);
    n_tests++;
    if (acc10 !== 10'd765 || ovf10 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got acc=%0d ovf=%0b, required 765 0", acc10, ovf10);
    end
    send(8'd1, 8'd2, 8'd3, 1'b1, 1'b1, w);
    in_valid = 1'b0;
    n_tests++;
    if (acc10 !== 10'd506 || ovf10 !== 1'b1 || acc16 !== 16'd1530 || ovf16 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_wrap: got acc10=%0d ovf10=%0b acc16=%0d ovf16=%0b, required 506 1 1530 0",
               acc10, ovf10, acc16, ovf16);
    end
    tick();
    n_tests++;
    if (acc10 !== 10'd6 || ovf10 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_reclr: got acc=%0d ovf=%0b, required 6 0", acc10, ovf10);
    end
    tick();
  endtask

  task automatic test_reset_pulse();
    int w;
    out_ready = 1'b1;
    send(8'd10, 8'd11, 8'd12, 1'b1, 1'b0, w);
    send(8'd13, 8'd14, 8'd15, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || ov10 !== 1'b0 || acc16 !== 16'd0 || acc10 !== 10'd0 || ovf10 !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pulse: got valid=%0b acc=%0d acc10=%0d in_ready=%0b, required 0 0 0 0",
               out_valid, acc16, acc10, in_ready);
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_stale: got out_valid=%0b on cycle %0d after release, required 0", out_valid, i);
      end
    end
    send(8'd10, 8'd20, 8'd30, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || z16 !== 10'd60 || acc16 !== 16'd60 || acc10 !== 10'd60) begin
      n_fail++;
      $display("FAIL rst_next: got valid=%0b z=%0d acc=%0d acc10=%0d, required 1 60 60 60",
               out_valid, z16, acc16, acc10);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_corner();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_pulse();
    repeat (4) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d beats never emitted, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
